// File: rtl/my_enc_pkg.sv
// Shared constants for the round-robin request encoder.
// RR_FAIR_EN selects round-robin (defined) or fixed priority (undefined).
package my_enc_pkg;
  localparam int N_REQ = 32;
  localparam int IDX_W = 5;
endpackage

// File: rtl/my_prio_enc.sv
// Combinational lowest-set-bit finder over the request vector.
// Used by my_rr_encoder; no state, no configuration.
module my_prio_enc
  import my_enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/my_rr_encoder.sv
// Registered 32-to-5 request encoder with valid/ready output.
// RR_FAIR_EN: round-robin search pointer; otherwise lowest index wins.
module my_rr_encoder
  import my_enc_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] grant
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hs, load, found;
  logic [N_REQ-1:0] idx_oh, req_m, rot;
  logic [IDX_W-1:0] enc_idx, sel;

  assign hs     = valid_q && out_ready;
  assign load   = en && (!valid_q || hs);
  assign idx_oh = N_REQ'(1) << idx_q;
  // The winner being accepted must not win again this cycle.
  assign req_m  = hs ? (req & ~idx_oh) : req;

`ifdef RR_FAIR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [2*N_REQ-1:0] dbl;

  assign dbl   = {req_m, req_m} >> ptr_q;
  assign rot   = dbl[N_REQ-1:0];
  assign sel   = enc_idx + ptr_q;
  assign ptr_d = (load && found) ? sel + IDX_W'(1) : ptr_q;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) ptr_q <= '0;
    else               ptr_q <= ptr_d;
  end
`else
  assign rot = req_m;
  assign sel = enc_idx;
`endif

  my_prio_enc u_prio (
    .vec_i   (rot),
    .idx_o   (enc_idx),
    .found_o (found)
  );

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = found;
      if (found) idx_d = sel;
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign grant     = hs ? idx_oh : '0;

endmodule

// File: doc/my_rr_encoder.md
# my_rr_encoder

Registered 32-to-5 round-robin request encoder with a valid/ready output handshake. It is the inverse of the register-file write-select decoder. It takes a multi-hot vector of 32 requesters, picks one per cycle, and presents its 5-bit index to the downstream consumer, for example a shared register-file port. On each accepted transfer it returns a one-hot grant to the winning requester.

## Interface
Parameters:
- N_REQ, 32, number of requesters; fixed at 32 in this revision.
- IDX_W, 5, index width; must equal clog2(N_REQ).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- en  input  1  selection enable; when 0, no new index is loaded.
- req  input  N_REQ  multi-hot request vector; bit k is requester k.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a selected requester.
- out_idx  output  IDX_W  encoded index of the selected requester.
- grant  output  N_REQ  one-hot, combinational: onehot(out_idx) when out_valid && out_ready, else 0.

## Operation
- State registers:
  - out_valid.
  - out_idx.
  - ptr[IDX_W-1:0], the search start point.
- Reset value of every output and register:
  - out_valid = 0, out_idx = 0, ptr = 0.
  - grant = 0, because it is derived from out_valid.
- Handshake: hs = out_valid && out_ready.
- Load condition: load = en && (!out_valid || hs).
- Masked request: req_m = req with bit out_idx cleared when hs. A winner is never reselected in the cycle it is accepted.
- Selection: the first set bit of req_m searching upward from ptr, wrapping from 31 to 0.
- On load with req_m != 0:
  - out_valid <= 1.
  - out_idx <= sel.
  - ptr <= sel + 1 mod 32; 31 wraps to 0.
- On load with req_m == 0:
  - out_valid <= 0.
  - out_idx and ptr are held.
- When load = 0: out_valid, out_idx and ptr are all held.
- Stability: while out_valid && !out_ready, out_idx is stable regardless of changes on req or en. A requester that drops req while pending is still granted; the consumer tolerates this.
- en = 0 with hs: the transfer completes, then out_valid <= 0 on the next cycle.
- Requesters deassert req in the cycle after they see grant. A still-asserted bit is treated as a new request.

## Timing
- Latency: a request present at edge t (with load true) appears on out_idx / out_valid after edge t.
- Throughput: one transfer per cycle under continuous out_ready.
- grant is combinational from out_valid, out_idx and out_ready, with zero cycles of latency. It is not registered.
- Reset mid-operation:
  - out_valid falls immediately, asynchronously.
  - ptr returns to 0.
  - No grant occurs while ctrl_reset_n is low.
- First load after reset release takes place at the first rising edge with ctrl_reset_n high.

## Configuration
- Macro: RR_FAIR_EN.
- Defined: round-robin behaviour as above; ptr advances after each load.
- Undefined:
  - ptr is removed and the search always starts at bit 0, giving fixed priority with the lowest index winning.
  - Masking of the accepted bit still applies.

## Structure
- Package my_enc_pkg holds the N_REQ and IDX_W constants.
- Sub-module my_prio_enc is a combinational lowest-set-bit finder.
  - Inputs and outputs: 32-bit input, 5-bit index, found flag.
  - Round-robin use: the top level rotates req_m right by ptr, calls my_prio_enc, and adds ptr mod 32 back to the result.

## Test plan
- Reset: hold ctrl_reset_n = 0 with req = 0xFFFFFFFF -> out_valid = 0, out_idx = 0, grant = 0. Release -> out_valid = 1, out_idx = 0 one edge later.
- Single request: req = 0x00002000, out_ready = 1 -> out_idx = 13 and grant = 0x00002000 in the valid cycle. With req dropped, out_valid = 0 on the next cycle.
- Fairness, req = bits {0, 5, 31} held and out_ready = 1:
  - RR_FAIR_EN defined -> out_idx sequence 0, 5, 31, 0, 5.
  - RR_FAIR_EN undefined -> 0, 5, 0, 5.
- Backpressure: out_idx = 7 with out_ready = 0 for 3 cycles while req changes to 0x00000004 -> out_idx stays 7 and grant = 0. Raise out_ready -> grant = 0x00000080, and out_idx = 2 the next cycle.
- Wrap-around: after granting 31 with req = bits {3, 30} -> next out_idx = 3 (RR); ptr = 4.
- en gating and reset mid-op:
  - en = 0 with req nonzero and out_valid = 0 -> out_valid stays 0.
  - Drop ctrl_reset_n between edges while out_valid = 1 -> out_valid = 0 before the next edge.
